tdes_pass_scheduler: RTL
========================

// Module: tdes_pass_scheduler
// PURPOSE
//   Sequences the single-DES round core through the three passes of one 3DES block:
//   E(K1)-D(K2)-E(K3) for encrypt and D(K3)-E(K2)-D(K1) for decrypt.
//   Pops 64-bit blocks tagged with a mode from the input FIFO and pushes results to the output FIFO.
//   Arbitrates key-register updates from the APB side so that keys never change mid-block.
//   Sits between the APB register file/FIFOs (data addr 0/1, key addr 2, read addr 4) and the DES core.
// PARAMETERS
//   DATA_W    64   block width
//   TIMEOUT   64   max cycles in WAIT for core_done before abort (>=2)
//   CNT_W     16   width of completed-block counter
// PORTS
//   PCLK             in   1       clock, all logic rising-edge
//   PRESET           in   1       reset, synchronous, active-high
//   in_valid         in   1       input FIFO not empty
//   in_data          in   DATA_W  input FIFO head block
//   in_mode          in   1       head block mode: 0 = encrypt (addr 0), 1 = decrypt (addr 1)
//   in_pop           out  1       pop input FIFO head (1-cycle pulse)
//   key_update_req   in   1       APB side requests a key-register write
//   key_update_ack   out  1       key write granted; held while req is high
//   core_start       out  1       launch one DES pass (1-cycle pulse)
//   core_decrypt     out  1       pass direction: 1 = DES decrypt
//   core_key_sel     out  2       0=K1 1=K2 2=K3 (3 never driven)
//   core_din         out  DATA_W  pass input block
//   core_done        in   1       core result valid (1-cycle pulse, >=1 cycle after start)
//   core_dout        in   DATA_W  core result
//   out_full         in   1       output FIFO full
//   out_push         out  1       push out_data to output FIFO
//   out_data         out  DATA_W  completed 3DES block
//   busy             out  1       state != IDLE
//   err_timeout      out  1       sticky: a core pass timed out
//   err_clr          in   1       clears err_timeout
//   blk_count        out  CNT_W   completed blocks, wraps at 2^CNT_W
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; work reg, pass, timer, blk_count = 0. Reset mid-block drops the block, no push.
//   States: IDLE, ISSUE, WAIT, PUSH, KEYGRANT.
//   IDLE: key_update_req -> KEYGRANT (key wins over simultaneous in_valid);
//     else in_valid -> in_pop=1 this cycle, latch work<=in_data, mode<=in_mode, pass<=0 -> ISSUE.
//   ISSUE: core_start=1 one cycle; core_din=work; timer<=0 -> WAIT.
//   core_decrypt = mode ^ (pass==1); core_key_sel = mode ? 2-pass : pass; both held stable ISSUE..WAIT.
//   WAIT: core_done -> work<=core_dout; pass==2 -> PUSH, else pass++ -> ISSUE.
//     No done and timer==TIMEOUT-1 -> err_timeout<=1, block discarded -> IDLE. Otherwise timer++.
//   core_done outside WAIT is ignored.
//   PUSH: out_data=work (registered); out_push = !out_full (combinational on out_full);
//     on push blk_count++ -> IDLE; while out_full, hold in PUSH indefinitely (no timeout).
//   KEYGRANT: key_update_ack=1 while req high; req low -> IDLE (ack drops same cycle). No core activity.
//   key_update_req during a block: not acked until block is pushed or aborted and IDLE is re-entered.
//   err_clr and a new timeout in the same cycle: set wins.
//   Latency per block with core latency L (start->done): pop to push = 1 + 3*(L+1) + 1 cycles, out_full low.
//   Back-to-back: next in_pop no earlier than the cycle after out_push (one block in flight).
// TESTING
//   K1=K2=K3=0x133457799BBCDFF1, encrypt 0x0123456789ABCDEF, core L=4 -> out_data 0x85E813540F0AB405, pop->push 17 cycles.
//   Decrypt 0x85E813540F0AB405 with the same keys -> 0x0123456789ABCDEF; key_sel sequence 2,1,0; decrypt sequence 1,0,1.
//   4 blocks queued, out_full high 10 cycles on block 2 -> out_push held off, no pop of block 3, blk_count ends at 4.
//   key_update_req raised during pass 1 -> ack only after push; req+in_valid both high in IDLE -> ack, no pop.
//   core_done never returned -> err_timeout=1 after TIMEOUT cycles in WAIT, no push; err_clr -> 0; next block ok.
//   PRESET asserted in WAIT -> next cycle IDLE, all outputs 0, blk_count 0, no out_push.

Source files
------------

// File: rtl/tdes_pass_scheduler.sv
// Sequences one 3DES block through three single-DES core passes (E-D-E / D-E-D),
// moving blocks between FIFOs and granting key writes only between blocks.
module tdes_pass_scheduler #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              in_pop,
    input  logic              key_update_req,
    output logic              key_update_ack,
    output logic              core_start,
    output logic              core_decrypt,
    output logic [1:0]        core_key_sel,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              out_full,
    output logic              out_push,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  blk_count
);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, KEYGRANT} state_t;

    state_t            state;
    logic [DATA_W-1:0] work;
    logic              mode;
    logic [1:0]        pass;
    logic [TMR_W-1:0]  timer;
    logic              pass_active;

    assign pass_active    = (state == ISSUE) || (state == WAIT);
    assign in_pop         = (state == IDLE) && !key_update_req && in_valid;
    assign core_start     = (state == ISSUE);
    // Middle pass runs in the opposite direction; decrypt walks the keys K3..K1.
    assign core_decrypt   = pass_active && (mode ^ (pass == 2'd1));
    assign core_key_sel   = !pass_active ? 2'd0 : (mode ? (2'd2 - pass) : pass);
    assign core_din       = work;
    assign out_data       = work;
    assign out_push       = (state == PUSH) && !out_full;
    assign key_update_ack = (state == KEYGRANT) && key_update_req;
    assign busy           = (state != IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            work        <= '0;
            mode        <= 1'b0;
            pass        <= 2'd0;
            timer       <= '0;
            blk_count   <= '0;
            err_timeout <= 1'b0;
        end else begin
            // A timeout later in this block overrides the clear.
            if (err_clr) err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_update_req) begin
                        state <= KEYGRANT;
                    end else if (in_valid) begin
                        work  <= in_data;
                        mode  <= in_mode;
                        pass  <= 2'd0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        work <= core_dout;
                        if (pass == 2'd2) begin
                            state <= PUSH;
                        end else begin
                            pass  <= pass + 2'd1;
                            state <= ISSUE;
                        end
                    end else if (timer == TMR_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PUSH: begin
                    if (!out_full) begin
                        blk_count <= blk_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                KEYGRANT: begin
                    if (!key_update_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
